// File: rtl/fetch_pkg.sv
// Shared constants and types for the queued fetch stage.
// Queue entries pair a fetched instruction with its PC.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;
  localparam int PC_W    = 64;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/adder.sv
// Plain N-bit adder, carry out dropped.
// Used by the PC increment path.
module adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/fetch_fifo.sv
// Synchronous circular buffer with flush.
// Flush and reset both clear pointers and count.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[head];

  always_ff @(posedge clk) begin
    if (reset | flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

endmodule

// File: rtl/mux2.sv
// N-bit two-input multiplexer.
// Selects d1 when s is high.
module mux2 #(
  parameter int N = 64
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic         s,
  output logic [N-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/fetch_queued.sv
// Fetch stage: PC register, imem request, and an instruction
// queue feeding decode through a valid/ready handshake.
module fetch_queued
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter int          DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc_F,
  input  logic [N-1:0] PCBranch_F,
  output logic [N-1:0] imem_addr_F,
  output logic         imem_req_F,
  input  logic [31:0]  imem_data_F,
  output logic [31:0]  instr_D,
  output logic [N-1:0] pc_D,
  output logic         valid_D,
  input  logic         ready_D
);

  typedef struct packed {
    logic [N-1:0]       pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam int CW = $clog2(DEPTH + 1);

  entry_t        wr_e;
  entry_t        rd_e;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic [N-1:0]  pc_q;
  logic [N-1:0]  pc_inc;
  logic [N-1:0]  pc_tgt;
  logic [N-1:0]  pc_next;

  assign pop        = valid_D & ready_D;
  assign push       = ~PCSrc_F & (~full | pop);
  assign imem_req_F = push;

  // Redirect targets are forced to word alignment.
  assign pc_tgt = PCBranch_F & ~N'(3);

  adder #(.N(N)) u_inc (
    .a (pc_q),
    .b (N'(PC_INC)),
    .y (pc_inc)
  );

  mux2 #(.N(N)) u_sel (
    .d0 (pc_inc),
    .d1 (pc_tgt),
    .s  (PCSrc_F),
    .y  (pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (PCSrc_F | push) begin
      pc_q <= pc_next;
    end
  end

  assign imem_addr_F = pc_q;
  assign wr_e        = '{pc: pc_q, instr: imem_data_F};

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_q (
    .clk   (clk),
    .reset (reset),
    .flush (PCSrc_F),
    .push  (push),
    .pop   (pop),
    .wdata (wr_e),
    .rdata (rd_e),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign valid_D         = (count != '0);
  assign {pc_D, instr_D} = empty ? '0 : rd_e;

endmodule

// File: tb/tb_fetch_queued.sv
// Randomised scoreboard bench for fetch_queued against
// a queue-based reference model of the fetch stage.
module tb_fetch_queued;

  localparam int          N        = 64;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc_F;
  logic [63:0] PCBranch_F;
  logic [63:0] imem_addr_F;
  logic        imem_req_F;
  logic [31:0] imem_data_F;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        valid_D;
  logic        ready_D;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  logic [95:0] exp_q[$];
  logic [95:0] e;
  logic [63:0] mpc;
  logic        mpop;
  logic        mpush;

  fetch_queued #(
    .N        (N),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc_F     (PCSrc_F),
    .PCBranch_F  (PCBranch_F),
    .imem_addr_F (imem_addr_F),
    .imem_req_F  (imem_req_F),
    .imem_data_F (imem_data_F),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .valid_D     (valid_D),
    .ready_D     (ready_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  assign imem_data_F = imem_fn(imem_addr_F);

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares decode-side outputs against the scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (started) begin
      chk("valid_D", 64'(valid_D), 64'(exp_q.size() != 0));
      if (valid_D && ready_D && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty act=pop exp=none t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("pc_D", pc_D, e[95:32]);
          chk("instr_D", 64'(instr_D), 64'(e[31:0]));
        end
      end else if (!valid_D) begin
        chk("pc_D_idle", pc_D, 64'h0);
        chk("instr_D_idle", 64'(instr_D), 64'h0);
      end
    end
  end

  // Driver: applies one cycle of stimulus and advances the model.
  task automatic cyc(input logic rdy, input logic redir,
                     input logic [63:0] tgt, input logic rst);
    @(negedge clk);
    reset      = rst;
    ready_D    = rdy;
    PCSrc_F    = redir;
    PCBranch_F = tgt;
    mpop  = !rst && exp_q.size() != 0 && rdy;
    mpush = !rst && !redir && (exp_q.size() < DEPTH || mpop);
    #2;
    if (started && !rst) begin
      chk("imem_addr_F", imem_addr_F, mpc);
      chk("imem_req_F", 64'(imem_req_F), 64'(mpush));
    end
    if (rst) begin
      exp_q.delete();
      mpc = RESET_PC;
    end else if (redir) begin
      exp_q.delete();
      mpc = {tgt[63:2], 2'b00};
    end else if (mpush) begin
      exp_q.push_back({mpc, imem_fn(mpc)});
      mpc = mpc + 64'd4;
    end
  endtask

  initial begin
    reset      = 1'b1;
    ready_D    = 1'b0;
    PCSrc_F    = 1'b0;
    PCBranch_F = '0;
    mpc        = RESET_PC;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    started = 1'b1;
    // Fill with decode stalled, then drain two and redirect on pc 8.
    repeat (6) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 64'h103, 0);
    // Refill from 0x100, redirect while full.
    repeat (6) cyc(0, 0, 0, 0);
    cyc(0, 1, 64'h103, 0);
    repeat (6) cyc(1, 0, 0, 0);
    // PC wraps past the top of the address space.
    cyc(1, 1, 64'hffff_ffff_ffff_fffc, 0);
    repeat (4) cyc(1, 0, 0, 0);
    // Reset with entries queued and a redirect pending.
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 64'h2000, 1);
    repeat (3) cyc(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 63) == 0);
      cyc(r ? 1'b0 : ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0),
          {$urandom, $urandom}, r);
    end
    repeat (2) cyc(1, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queued.md
# fetch_queued

Parametrised successor to the pipeline fetch stage: holds the PC, issues instruction-memory addresses and buffers fetched instructions with their PCs in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake, so decode stalls do not stop fetch until the queue is full. A branch redirect reloads the PC and flushes the queue. Sits between instruction memory and the IF/ID boundary of the pipelined core.

## Interface
Parameters:
- N, 64: PC / address width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- PCSrc_F  in  1  redirect request.
- PCBranch_F  in  N  redirect target.
- imem_addr_F  out  N  instruction-memory address (= PC register).
- imem_req_F  out  1  fetch at imem_addr_F is accepted this cycle.
- imem_data_F  in  32  instruction at imem_addr_F; combinational, same cycle.
- instr_D  out  32  head instruction.
- pc_D  out  N  PC of head instruction.
- valid_D  out  1  head entry present.
- ready_D  in  1  decode accepts head this cycle.

## Operation
- pop = valid_D & ready_D.
- push = ~PCSrc_F & (count < DEPTH | pop); imem_req_F = push.
- PC update priority: reset → RESET_PC; else PCSrc_F → {PCBranch_F[N-1:2], 2'b00}; else push → PC + 4 (mod 2^N, wraps silently); else hold.
- Redirect: queue cleared (count = 0, pointers = 0) at the edge; no push that cycle; a pop in the same cycle completes (decode keeps the instruction), then the queue is cleared.
- Push: entry {PC, imem_data_F} written at tail; tail++ (mod DEPTH).
- Pop: head++ (mod DEPTH).
- push & pop together on a full queue: both occur, count unchanged.
- count: +1 push only, −1 pop only, unchanged both/neither.
- valid_D = (count != 0). instr_D/pc_D = head entry when valid_D, else 0.
- No bypass: a pushed instruction is visible on instr_D no earlier than the next cycle.
- ready_D while valid_D = 0 has no effect.

## Timing
- Reset (sync, any cycle incl. mid-stream or with PCSrc_F high): next cycle imem_addr_F = RESET_PC, valid_D = 0, instr_D = 0, pc_D = 0, count = 0. imem_req_F is 1 in the first post-reset cycle (queue empty, PCSrc_F low).
- Fetch-to-decode latency: 1 cycle (fetched in cycle c → valid_D in c+1 if queue was empty).
- Redirect at cycle t: imem_addr_F = target in t+1, first target instruction on valid_D in t+2.
- Steady state with ready_D = 1: one instruction per cycle, count stays 1.
- ready_D = 0: fetch continues until count = DEPTH, then imem_req_F = 0 and PC holds.
- All outputs registered or decoded from registers except imem_req_F (depends on PCSrc_F, ready_D).

## Structure
- Package fetch_pkg: INSTR_W = 32, PC_INC = 4, typedef fetch_entry_t (struct: pc[N-1:0], instr[INSTR_W-1:0]); N-dependent fields via parameterised struct or per-field declaration in the module.
- Sub-module fetch_fifo: synchronous circular buffer, parameters WIDTH, DEPTH; ports clk, reset, flush, push, pop, wdata, rdata, count, full, empty. Count width $clog2(DEPTH+1).
- PC path reuses the existing adder (N) and mux2 (N) modules; PC register is a flopr with enable, or inline.

## Test plan
- Reset, ready_D = 1, imem returns addr-tagged words → instr_D/pc_D sequence 0,4,8,12 starting cycle 2, valid_D continuous.
- ready_D = 0 from reset, DEPTH = 4 → imem_req_F high 4 cycles, then 0; imem_addr_F holds 16; raise ready_D → entries 0,4,8,12 drained in order, fetch resumes at 16 in the same cycle as the first pop.
- Queue full with pc 0..12, PCSrc_F = 1, PCBranch_F = 0x103 → next cycle valid_D = 0, imem_addr_F = 0x100; cycle after, pc_D = 0x100.
- Redirect coincident with pop of head pc 8 → handshake completes, queue empty next cycle, no stale entry appears.
- RESET_PC = 2^N − 4 (N = 64) → second fetch address 0 (wrap), no error.
- Reset asserted with count = 3 and PCSrc_F = 1 → next cycle imem_addr_F = RESET_PC, valid_D = 0, pc_D = 0, instr_D = 0.
